// File: rtl/slc3_button_conditioner.sv
// SLC-3 input conditioning: 2-flop synchronizers for Run/Continue/SW plus per-button debounce FSMs.
// Optional macro CONTINUE_AUTOREPEAT_EN adds periodic Continue_pulse repeats while Continue is held.

module slc3_button_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_CYCLES   = 64,
    parameter bit REPEAT_EN       = 1'b0
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic pressed,
    output logic pulse,
    output logic held
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    localparam int             CW   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

    state_t        state, state_nx;
    logic [CW-1:0] count, count_nx;
    logic          pulse_nx;
    logic          held_nx;
    logic          repeat_fire;

    // NOTE: every flop resets asynchronously and is updated with <= so all
    // state sampled in one edge sees the pre-edge values of its neighbours.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            count <= '0;
            pulse <= 1'b0;
            held  <= 1'b0;
        end else begin
            state <= state_nx;
            count <= count_nx;
            pulse <= pulse_nx;
            held  <= held_nx;
        end
    end

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        state_nx = state;
        count_nx = count;
        pulse_nx = 1'b0;
        case (state)
            IDLE: begin
                if (pressed) begin
                    state_nx = PRESS_WAIT;
                    count_nx = CW'(1);
                end
            end
            PRESS_WAIT: begin
                if (!pressed) begin
                    state_nx = IDLE;
                    count_nx = '0;
                end else if (count == LAST) begin
                    state_nx = HELD;
                    count_nx = '0;
                    pulse_nx = 1'b1;
                end else begin
                    count_nx = count + 1'b1;
                end
            end
            HELD: begin
                if (!pressed) begin
                    state_nx = RELEASE_WAIT;
                    count_nx = CW'(1);
                end else if (repeat_fire) begin
                    pulse_nx = 1'b1;
                end
            end
            RELEASE_WAIT: begin
                if (pressed) begin
                    state_nx = HELD;
                    count_nx = '0;
                end else if (count == LAST) begin
                    state_nx = IDLE;
                    count_nx = '0;
                end else begin
                    count_nx = count + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                count_nx = '0;
            end
        endcase
        held_nx = (state_nx == HELD) || (state_nx == RELEASE_WAIT);
    end

    // Repeat timer only advances while staying in HELD; any exit restarts it from zero.
    if (REPEAT_EN) begin : g_repeat
        localparam int             RW    = $clog2(REPEAT_CYCLES) + 1;
        localparam logic [RW-1:0]  RLAST = RW'(REPEAT_CYCLES - 1);

        logic [RW-1:0] rep_cnt;

        always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n) begin
                rep_cnt <= '0;
            end else if ((state == HELD) && (state_nx == HELD)) begin
                rep_cnt <= repeat_fire ? '0 : rep_cnt + 1'b1;
            end else begin
                rep_cnt <= '0;
            end
        end

        assign repeat_fire = (state == HELD) && (rep_cnt == RLAST);
    end else begin : g_no_repeat
        assign repeat_fire = 1'b0;
    end

endmodule

module slc3_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_CYCLES   = 64
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Run,
    input  logic       Continue,
    input  logic [9:0] SW,
    output logic       Run_pulse,
    output logic       Continue_pulse,
    output logic       Run_held,
    output logic       Continue_held,
    output logic [9:0] SW_sync
);

`ifdef CONTINUE_AUTOREPEAT_EN
    localparam bit CONT_REPEAT = 1'b1;
`else
    localparam bit CONT_REPEAT = 1'b0;
`endif

    logic [1:0] run_sync;
    logic [1:0] cont_sync;
    logic [9:0] sw_meta;

    // Button synchronizers come out of reset as "released" so a held button
    // is seen as a fresh press once reset lifts.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            run_sync  <= 2'b11;
            cont_sync <= 2'b11;
            sw_meta   <= '0;
            SW_sync   <= '0;
        end else begin
            run_sync  <= {run_sync[0], Run};
            cont_sync <= {cont_sync[0], Continue};
            sw_meta   <= SW;
            SW_sync   <= sw_meta;
        end
    end

    slc3_button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES),
        .REPEAT_EN       (1'b0)
    ) u_run_db (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .pressed (~run_sync[1]),
        .pulse   (Run_pulse),
        .held    (Run_held)
    );

    slc3_button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES),
        .REPEAT_EN       (CONT_REPEAT)
    ) u_cont_db (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .pressed (~cont_sync[1]),
        .pulse   (Continue_pulse),
        .held    (Continue_held)
    );

endmodule

// File: tb/tb_slc3_button_conditioner.sv
// Scoreboard bench for slc3_button_conditioner: a debounced-level reference model predicts every
// cycle's outputs; a monitor compares them, and directed scenarios check the documented latencies.

module tb_slc3_button_conditioner;

    localparam int D = 4;
    localparam int R = 16;
`ifdef CONTINUE_AUTOREPEAT_EN
    localparam bit CONT_REP = 1'b1;
`else
    localparam bit CONT_REP = 1'b0;
`endif
    localparam int LONG_HOLD_CONT = CONT_REP ? 4 : 1;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b1;
    logic       Run = 1'b1;
    logic       Continue = 1'b1;
    logic [9:0] SW = '0;
    logic       Run_pulse, Continue_pulse, Run_held, Continue_held;
    logic [9:0] SW_sync;

    slc3_button_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_CYCLES   (R)
    ) dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .Run            (Run),
        .Continue       (Continue),
        .SW             (SW),
        .Run_pulse      (Run_pulse),
        .Continue_pulse (Continue_pulse),
        .Run_held       (Run_held),
        .Continue_held  (Continue_held),
        .SW_sync        (SW_sync)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: a button's accepted level flips once D consecutive synced
    // samples disagree with it; pins reach the model two edges late.
    typedef struct {
        bit deb;
        int streak;
        int since;
        bit p1;
        bit p2;
    } btn_m_t;

    typedef struct packed {
        logic       rp;
        logic       cp;
        logic       rh;
        logic       ch;
        logic [9:0] sw;
    } exp_t;

    exp_t       exp_q[$];
    btn_m_t     rm = '{default: 0};
    btn_m_t     cm = '{default: 0};
    logic [9:0] sw_p1 = '0;

    function automatic void btn_step(inout btn_m_t b, input bit pressed_now, input bit rep_en,
                                     output bit pulse);
        bit s;
        s      = b.p2;
        b.p2   = b.p1;
        b.p1   = pressed_now;
        pulse  = 1'b0;
        if (!b.deb) begin
            if (s) begin
                b.streak++;
                if (b.streak == D) begin
                    b.deb = 1'b1;
                    b.streak = 0;
                    b.since = 0;
                    pulse = 1'b1;
                end
            end else begin
                b.streak = 0;
            end
        end else begin
            if (!s) begin
                b.streak++;
                b.since = 0;
                if (b.streak == D) begin
                    b.deb = 1'b0;
                    b.streak = 0;
                end
            end else if (b.streak > 0) begin
                b.streak = 0;
                b.since = 0;
            end else if (rep_en) begin
                b.since++;
                if (b.since == R) begin
                    pulse = 1'b1;
                    b.since = 0;
                end
            end
        end
    endfunction

    always @(posedge Clk or negedge Reset_n) begin
        exp_t e;
        bit   rp, cp;
        if (!Reset_n) begin
            rm    = '{default: 0};
            cm    = '{default: 0};
            sw_p1 = '0;
            exp_q.delete();
        end else begin
            btn_step(rm, !Run, 1'b0, rp);
            btn_step(cm, !Continue, CONT_REP, cp);
            e.rp  = rp;
            e.cp  = cp;
            e.rh  = rm.deb;
            e.ch  = cm.deb;
            e.sw  = sw_p1;
            sw_p1 = SW;
            exp_q.push_back(e);
        end
    end

    // Monitor: compares the DUT after every edge and tallies observed events.
    int run_pulse_cnt = 0;
    int cont_pulse_cnt = 0;
    bit cont_held_seen = 1'b0;
    bit cont_held_dropped = 1'b0;

    always @(posedge Clk) begin
        exp_t e;
        #1;
        if (!Reset_n) begin
            check("reset_outputs", {Run_pulse, Continue_pulse, Run_held, Continue_held, SW_sync},
                  14'h0);
        end else if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("run_pulse", Run_pulse, e.rp);
            check("cont_pulse", Continue_pulse, e.cp);
            check("run_held", Run_held, e.rh);
            check("cont_held", Continue_held, e.ch);
            check("sw_sync", SW_sync, e.sw);
            if (Run_pulse === 1'b1) run_pulse_cnt++;
            if (Continue_pulse === 1'b1) cont_pulse_cnt++;
            if (Continue_held === 1'b1) cont_held_seen = 1'b1;
            if (Continue_held === 1'b0) cont_held_dropped = 1'b1;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // Counts edges (edge 1 = the next rising edge) until the selected output reaches level.
    task automatic wait_sig(input int sel, input logic level, input int limit, output int n);
        logic v;
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge Clk);
            #1;
            case (sel)
                0:       v = Run_pulse;
                1:       v = Continue_pulse;
                2:       v = Run_held;
                default: v = Continue_held;
            endcase
            if (v === level) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int c0, r0;

        // Reset with both buttons pressed: fresh presses accepted together after release.
        Run = 1'b0;
        Continue = 1'b0;
        #1 Reset_n = 1'b0;
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        wait_sig(0, 1'b1, 30, n);
        check("reset_release_run_latency", n, D + 2);
        check("reset_release_cont_simultaneous", Continue_pulse, 1'b1);
        @(negedge Clk);
        Run = 1'b1;
        Continue = 1'b1;
        idle(12);

        // Clean Continue press held 20 cycles.
        Continue = 1'b0;
        wait_sig(1, 1'b1, 30, n);
        check("clean_press_latency", n, D + 2);
        check("clean_press_held", Continue_held, 1'b1);
        idle(14);
        Continue = 1'b1;
        wait_sig(3, 1'b0, 30, n);
        check("clean_release_latency", n, D + 2);
        idle(8);

        // Bounce rejection.
        c0 = cont_pulse_cnt;
        cont_held_seen = 1'b0;
        Continue = 1'b0; idle(3);
        Continue = 1'b1; idle(1);
        Continue = 1'b0; idle(3);
        Continue = 1'b1; idle(12);
        check("bounce_no_pulse", cont_pulse_cnt - c0, 0);
        check("bounce_no_held", cont_held_seen, 1'b0);

        // Release bounce while held.
        Continue = 1'b0;
        wait_sig(3, 1'b1, 30, n);
        @(negedge Clk);
        c0 = cont_pulse_cnt;
        cont_held_dropped = 1'b0;
        idle(3);
        Continue = 1'b1; idle(2);
        Continue = 1'b0; idle(8);
        check("release_bounce_held_kept", cont_held_dropped, 1'b0);
        check("release_bounce_no_pulse", cont_pulse_cnt - c0, 0);
        Continue = 1'b1;
        idle(12);

        // Switches pass through with two edges of latency.
        SW = 10'h2A5;
        n = -1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge Clk);
            #1;
            if (SW_sync === 10'h2A5) begin
                n = i;
                break;
            end
        end
        check("sw_latency", n, 2);
        idle(2);

        // Long hold of both buttons: Run pulses once, Continue repeats only when enabled.
        c0 = cont_pulse_cnt;
        r0 = run_pulse_cnt;
        Run = 1'b0;
        Continue = 1'b0;
        wait_sig(1, 1'b1, 30, n);
        check("long_hold_latency", n, D + 2);
        check("long_hold_run_simultaneous", Run_pulse, 1'b1);
        repeat (60) @(posedge Clk);
        #2;
        check("long_hold_cont_pulses", cont_pulse_cnt - c0, LONG_HOLD_CONT);
        check("long_hold_run_pulses", run_pulse_cnt - r0, 1);
        @(negedge Clk);
        Run = 1'b1;
        Continue = 1'b1;
        idle(12);

        // Asynchronous reset while held; button kept down through release is a fresh press.
        Run = 1'b0;
        wait_sig(2, 1'b1, 30, n);
        idle(3);
        @(posedge Clk);
        #3 Reset_n = 1'b0;
        #1;
        check("async_reset_held_drop", Run_held, 1'b0);
        check("async_reset_sw_clear", SW_sync, 10'h000);
        idle(2);
        Reset_n = 1'b1;
        wait_sig(0, 1'b1, 30, n);
        check("held_through_reset_latency", n, D + 2);
        @(negedge Clk);
        Run = 1'b1;
        idle(12);

        // Asynchronous reset mid-debounce: no pulse afterwards.
        Continue = 1'b0;
        idle(4);
        @(posedge Clk);
        #3 Reset_n = 1'b0;
        #1;
        check("async_reset_mid_debounce", {Continue_held, Continue_pulse}, 2'b00);
        Continue = 1'b1;
        @(negedge Clk);
        Reset_n = 1'b1;
        c0 = cont_pulse_cnt;
        idle(12);
        check("mid_debounce_reset_no_pulse", cont_pulse_cnt - c0, 0);

        // Random button activity and switch traffic, checked cycle by cycle by the monitor.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(5) == 0) Run = ~Run;
            if ($urandom_range(5) == 0) Continue = ~Continue;
            if ($urandom_range(3) == 0) SW = 10'($urandom);
            @(negedge Clk);
        end
        Run = 1'b1;
        Continue = 1'b1;
        idle(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
